baud_generator: RTL and testbench
=================================

Name: baud_generator

Overview:
- Programmable UART baud-tick generator.
- From one system clock, produces a single-cycle transmit tick `intx` at the selected baud rate.
- Also produces a single-cycle receive tick `inrx` at 16x the selected baud rate, for receiver oversampling.
- Sits between the system clock and the UART TX/RX state machines; the rate is picked at run time via a 2-bit select.

Parameters:
- CLK_FREQ, 150_000_000, system clock frequency in Hz.
- BAUD0, 4800, rate for baud_sel=00.
- BAUD1, 19200, rate for baud_sel=01.
- BAUD2, 460800, rate for baud_sel=10.
- BAUD3, 921600, rate for baud_sel=11.
- OVERSAMPLE, 16, RX ticks per bit period.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- baud_sel  input  2  baud-rate select, synchronous to clk.
- intx  output  1  TX baud tick, one clk wide.
- inrx  output  1  RX oversample tick, one clk wide.

Behaviour:
- Divisors are computed at elaboration with round-to-nearest:
  - TX_DIVn = (CLK_FREQ + BAUDn/2) / BAUDn
  - RX_DIVn = (CLK_FREQ + OVERSAMPLE*BAUDn/2) / (OVERSAMPLE*BAUDn)
- Default divisors:
  - TX = 31250, 7813, 326, 163
  - RX = 1953, 488, 20, 10
- Elaboration error if any divisor < 2.
- Counter widths are derived with $clog2 of the largest divisor.
- TX counter:
  - Counts 0..TX_DIV-1 and wraps to 0.
  - intx is registered: 1 for exactly the one cycle after the counter holds TX_DIV-1, else 0.
- RX counter: identical behaviour with RX_DIV, driving inrx.
- Tick timing:
  - After reset deassertion, the first intx is high on cycle TX_DIV and the first inrx on cycle RX_DIV (cycle 1 = first rising edge with reset high).
  - Period is exactly TX_DIV / RX_DIV cycles thereafter.
  - Duty: high for 1 cycle per period.
- Reset asserted (reset=0), at any time including mid-count:
  - Counters clear to 0 and intx = inrx = 0 immediately (asynchronous).
  - The sel-tracking register loads the current baud_sel.
- baud_sel change:
  - A registered copy of baud_sel is compared each cycle.
  - On the cycle a difference is detected, both counters clear to 0 and the new divisors are used.
  - No tick is issued on that cycle, even if a counter was at terminal count.
  - The first tick at the new rate follows the full new divisor count.
  - No runt or double ticks ever occur.
- TX and RX counters are independent: phase alignment between intx and inrx is not guaranteed, except via the optional feature.
- baud_sel held stable generates no restarts.

Optional Feature:
- Macro BAUD_TX_FROM_RX_EN.
- When defined:
  - The TX counter is removed.
  - A 4-bit (log2 OVERSAMPLE) counter counts inrx ticks.
  - intx pulses in the same cycle as every 16th inrx, i.e. coincident with that inrx, so TX is phase-locked to RX.
  - TX period = OVERSAMPLE*RX_DIV (4800 baud: 31248 cycles).
  - Reset and sel-change also clear this counter.
- When undefined: independent TX counter as above.

Test Plan:
- Reset check: hold reset=0 for 2 cycles with baud_sel=01 -> intx=0 and inrx=0 throughout; also assert reset mid-count -> outputs drop to 0 without waiting for a clock edge.
- baud_sel=01, release reset:
  - first inrx on cycle 488, then every 488 cycles.
  - first intx on cycle 7813, then every 7813 cycles.
  - each pulse exactly 1 cycle wide.
- baud_sel=10: inrx period 20, intx period 326; over 500000 ns (10 ns clk) count intx=153±1 and inrx=2500.
- baud_sel=11: inrx period 10, intx period 163; baud_sel=00: intx period 31250, inrx period 1953.
- Switch baud_sel 01->11 when the RX counter is at 487 -> no tick in the switch cycle; next inrx exactly 10 cycles after the change cycle; no pulse is ever shorter or longer than 1 cycle.
- With BAUD_TX_FROM_RX_EN, sel=00 -> every intx coincides with an inrx; intx period 31248 cycles.

Source files
------------

// File: rtl/baud_generator.sv
// Programmable UART baud-tick generator: one-cycle TX tick at the selected baud rate
// and one-cycle RX tick at OVERSAMPLE x that rate. Define BAUD_TX_FROM_RX_EN to phase-lock TX to RX.
module baud_generator #(
    parameter int unsigned CLK_FREQ   = 150_000_000,
    parameter int unsigned BAUD0      = 4800,
    parameter int unsigned BAUD1      = 19200,
    parameter int unsigned BAUD2      = 460800,
    parameter int unsigned BAUD3      = 921600,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] baud_sel,
    output logic       intx,
    output logic       inrx
);

    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // Round-to-nearest divisors
    localparam int unsigned TX_DIV0 = (CLK_FREQ + BAUD0 / 2) / BAUD0;
    localparam int unsigned TX_DIV1 = (CLK_FREQ + BAUD1 / 2) / BAUD1;
    localparam int unsigned TX_DIV2 = (CLK_FREQ + BAUD2 / 2) / BAUD2;
    localparam int unsigned TX_DIV3 = (CLK_FREQ + BAUD3 / 2) / BAUD3;

    localparam int unsigned RX_DIV0 = (CLK_FREQ + OVERSAMPLE * BAUD0 / 2) / (OVERSAMPLE * BAUD0);
    localparam int unsigned RX_DIV1 = (CLK_FREQ + OVERSAMPLE * BAUD1 / 2) / (OVERSAMPLE * BAUD1);
    localparam int unsigned RX_DIV2 = (CLK_FREQ + OVERSAMPLE * BAUD2 / 2) / (OVERSAMPLE * BAUD2);
    localparam int unsigned RX_DIV3 = (CLK_FREQ + OVERSAMPLE * BAUD3 / 2) / (OVERSAMPLE * BAUD3);

    localparam int unsigned RX_MAX = max4(RX_DIV0, RX_DIV1, RX_DIV2, RX_DIV3);
    localparam int unsigned RX_W   = $clog2(RX_MAX);

    if (TX_DIV0 < 2 || TX_DIV1 < 2 || TX_DIV2 < 2 || TX_DIV3 < 2) begin : g_bad_tx_div
        $error("baud_generator: a TX divisor is below 2");
    end
    if (RX_DIV0 < 2 || RX_DIV1 < 2 || RX_DIV2 < 2 || RX_DIV3 < 2) begin : g_bad_rx_div
        $error("baud_generator: an RX divisor is below 2");
    end
    if (OVERSAMPLE < 2) begin : g_bad_os
        $error("baud_generator: OVERSAMPLE must be at least 2");
    end

    // Sel tracking: sel_vld_q marks that sel_q holds a sample taken while out of reset
    logic [1:0]      sel_q, sel_d;
    logic            sel_vld_q, sel_vld_d;
    logic            sel_chg_c;

    logic [RX_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [RX_W-1:0] rx_term_c;
    logic            rx_wrap_c;
    logic            rx_tick_q, rx_tick_d;

    logic            tx_tick_q, tx_tick_d;

`ifdef BAUD_TX_FROM_RX_EN
    localparam int unsigned OS_W = $clog2(OVERSAMPLE);

    logic [OS_W-1:0] sub_cnt_q, sub_cnt_d;
    logic            sub_wrap_c;
`else
    localparam int unsigned TX_MAX = max4(TX_DIV0, TX_DIV1, TX_DIV2, TX_DIV3);
    localparam int unsigned TX_W   = $clog2(TX_MAX);

    logic [TX_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [TX_W-1:0] tx_term_c;
    logic            tx_wrap_c;
`endif

    // Terminal-count selection; baud_sel is used directly since a change restarts the counters
    always_comb begin
        rx_term_c = RX_W'(RX_DIV0 - 1);
        case (baud_sel)
            2'b00:   rx_term_c = RX_W'(RX_DIV0 - 1);
            2'b01:   rx_term_c = RX_W'(RX_DIV1 - 1);
            2'b10:   rx_term_c = RX_W'(RX_DIV2 - 1);
            default: rx_term_c = RX_W'(RX_DIV3 - 1);
        endcase
    end

`ifndef BAUD_TX_FROM_RX_EN
    always_comb begin
        tx_term_c = TX_W'(TX_DIV0 - 1);
        case (baud_sel)
            2'b00:   tx_term_c = TX_W'(TX_DIV0 - 1);
            2'b01:   tx_term_c = TX_W'(TX_DIV1 - 1);
            2'b10:   tx_term_c = TX_W'(TX_DIV2 - 1);
            default: tx_term_c = TX_W'(TX_DIV3 - 1);
        endcase
    end
`endif

    // Next-state logic: a sel change clears every counter and suppresses that cycle's ticks
    always_comb begin
        sel_d     = baud_sel;
        sel_vld_d = 1'b1;
        sel_chg_c = sel_vld_q && (baud_sel != sel_q);

        rx_wrap_c = (rx_cnt_q >= rx_term_c);
        rx_cnt_d  = rx_wrap_c ? '0 : rx_cnt_q + RX_W'(1);
        rx_tick_d = rx_wrap_c;

`ifdef BAUD_TX_FROM_RX_EN
        sub_wrap_c = (sub_cnt_q == OS_W'(OVERSAMPLE - 1));
        sub_cnt_d  = sub_cnt_q;
        if (rx_wrap_c) begin
            sub_cnt_d = sub_wrap_c ? '0 : sub_cnt_q + OS_W'(1);
        end
        tx_tick_d  = rx_wrap_c && sub_wrap_c;
`else
        tx_wrap_c = (tx_cnt_q >= tx_term_c);
        tx_cnt_d  = tx_wrap_c ? '0 : tx_cnt_q + TX_W'(1);
        tx_tick_d = tx_wrap_c;
`endif

        if (sel_chg_c) begin
            rx_cnt_d  = '0;
            rx_tick_d = 1'b0;
            tx_tick_d = 1'b0;
`ifdef BAUD_TX_FROM_RX_EN
            sub_cnt_d = '0;
`else
            tx_cnt_d  = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel_q     <= '0;
            sel_vld_q <= 1'b0;
            rx_cnt_q  <= '0;
            rx_tick_q <= 1'b0;
            tx_tick_q <= 1'b0;
        end else begin
            sel_q     <= sel_d;
            sel_vld_q <= sel_vld_d;
            rx_cnt_q  <= rx_cnt_d;
            rx_tick_q <= rx_tick_d;
            tx_tick_q <= tx_tick_d;
        end
    end

`ifdef BAUD_TX_FROM_RX_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sub_cnt_q <= '0;
        end else begin
            sub_cnt_q <= sub_cnt_d;
        end
    end
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_cnt_q <= '0;
        end else begin
            tx_cnt_q <= tx_cnt_d;
        end
    end
`endif

    assign intx = tx_tick_q;
    assign inrx = rx_tick_q;

endmodule

// File: tb/tb_baud_generator.sv
// Self-checking bench for baud_generator (default build): ticks are predicted from
// "one pulse every DIV cycles since the last restart" with restarts at reset and sel change.
module tb_baud_generator;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] baud_sel = 2'b01;
    logic       intx;
    logic       inrx;

    always #5 clk = ~clk;

    baud_generator dut (
        .clk      (clk),
        .reset    (reset),
        .baud_sel (baud_sel),
        .intx     (intx),
        .inrx     (inrx)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    int unsigned tx_div [4] = '{31250, 7813, 326, 163};
    int unsigned rx_div [4] = '{1953, 488, 20, 10};

    // Reference model state: selection in force and edges since the last restart
    logic [1:0]  m_sel;
    int unsigned m_n;
    int unsigned tx_cnt, rx_cnt, first_tx, first_rx;

    typedef struct {
        logic [1:0]  sel;
        int unsigned cycles;
        int unsigned first_tx;
        int unsigned first_rx;
        int unsigned n_tx;
        int unsigned n_rx;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_stats();
        tx_cnt   = 0;
        rx_cnt   = 0;
        first_tx = 0;
        first_rx = 0;
    endtask

    // One clock: advance the model on the edge, then compare both ticks 2 ns later
    task automatic cycle();
        logic exp_tx, exp_rx;
        @(posedge clk);
        if (baud_sel != m_sel) begin
            m_sel = baud_sel;
            m_n   = 0;
        end else begin
            m_n++;
        end
        #2;
        exp_tx = (m_n != 0) && (m_n % tx_div[m_sel] == 0);
        exp_rx = (m_n != 0) && (m_n % rx_div[m_sel] == 0);
        check("intx", 32'(intx), 32'(exp_tx));
        check("inrx", 32'(inrx), 32'(exp_rx));
        if (intx) begin
            tx_cnt++;
            if (first_tx == 0) first_tx = m_n;
        end
        if (inrx) begin
            rx_cnt++;
            if (first_rx == 0) first_rx = m_n;
        end
    endtask

    task automatic do_reset(input logic [1:0] sel);
        reset    = 1'b0;
        baud_sel = sel;
        repeat (2) begin
            @(posedge clk);
            #2;
            check("rst_intx", 32'(intx), 0);
            check("rst_inrx", 32'(inrx), 0);
        end
        reset = 1'b1;
        m_sel = sel;
        m_n   = 0;
        clear_stats();
    endtask

    initial begin
        int unsigned gap;
        logic        seen;

        vecs[0] = '{sel: 2'b01, cycles: 8000,  first_tx: 7813,  first_rx: 488,  n_tx: 1,  n_rx: 16};
        vecs[1] = '{sel: 2'b10, cycles: 25000, first_tx: 326,   first_rx: 20,   n_tx: 76, n_rx: 1250};
        vecs[2] = '{sel: 2'b11, cycles: 2000,  first_tx: 163,   first_rx: 10,   n_tx: 12, n_rx: 200};
        vecs[3] = '{sel: 2'b00, cycles: 31300, first_tx: 31250, first_rx: 1953, n_tx: 1,  n_rx: 16};

        #1;
        check("por_intx", 32'(intx), 0);
        check("por_inrx", 32'(inrx), 0);

        // Rate table: first-tick cycle, pulse counts, and per-cycle pulse shape
        for (int i = 0; i < 4; i++) begin
            do_reset(vecs[i].sel);
            repeat (vecs[i].cycles) cycle();
            check("first_tx", first_tx, vecs[i].first_tx);
            check("first_rx", first_rx, vecs[i].first_rx);
            check("num_tx", tx_cnt, vecs[i].n_tx);
            check("num_rx", rx_cnt, vecs[i].n_rx);
        end

        // Asynchronous reset while inrx is high drops it without a clock edge
        do_reset(2'b11);
        repeat (10) cycle();
        check("pre_async_inrx", 32'(inrx), 1);
        reset = 1'b0;
        #1;
        check("async_inrx", 32'(inrx), 0);
        check("async_intx", 32'(intx), 0);

        // Switch 01 -> 11 while the RX counter holds 487
        do_reset(2'b01);
        repeat (487) cycle();
        baud_sel = 2'b11;
        cycle();
        check("sw_cycle_inrx", 32'(inrx), 0);
        check("sw_cycle_intx", 32'(intx), 0);
        gap  = 0;
        seen = 1'b0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            cycle();
            if (inrx) begin
                seen = 1'b1;
                gap  = k;
            end
        end
        check("sw_gap_inrx", gap, 10);

        // Random sel changes (including rewrites of the same value) against the model
        do_reset(2'($urandom_range(1, 3)));
        for (int k = 0; k < 6000; k++) begin
            if ($urandom_range(0, 99) < 2) baud_sel = 2'($urandom_range(1, 3));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
